mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Shares one external memory bus (MREQ/WRITE/SIZE/ACK_n style, same signalling the core uses towards instruction and data memory) between the pipeline's instruction-fetch port and data-access port. Used when instruction and data memory are a single unified array. Data accesses get priority. A starvation counter guarantees that fetch is not locked out. Each requester sees a simple req/ack handshake; the bus side sees at most one outstanding transaction.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits (≥1)
- TIMEOUT, 16, bus cycles before abort (used only with MEMARB_TIMEOUT_EN)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetch data, valid with i_ack
- i_ack  out  1  one-cycle completion pulse
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store
- d_size  in  2  00 word, 01 half, 10 byte
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid with d_ack
- d_ack  out  1  one-cycle completion pulse
- bus_mreq  out  1  bus request
- bus_write  out  1  bus write
- bus_size  out  2  bus size, same encoding as d_size
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_rdata  in  DATA_W  bus read data
- bus_ack_n  in  1  active-low bus acknowledge
- err  out  1  one-cycle timeout pulse (constant 0 without macro)

## Operation
- States: IDLE, IBUS (fetch owns the bus), DBUS (data owns the bus).
- IDLE arbitration. Effective requests are i_req && !i_ack and d_req && !d_ack, so a just-acked requester is masked for one cycle.
  - Data only: go to DBUS.
  - Fetch only: go to IBUS.
  - Both, with starve_cnt < STARVE_MAX: go to DBUS and increment starve_cnt.
  - Both, with starve_cnt == STARVE_MAX: go to IBUS.
- starve_cnt clears on every IBUS entry. It also clears on any IDLE cycle with no effective fetch request.
- On grant, the bus outputs register the winner's fields:
  - Fetch: bus_write=0, bus_size=00.
  - Data: bus_write=d_we, bus_size=d_size, bus_wdata=d_wdata.
- bus_mreq=1 for the whole IBUS/DBUS residency. All bus fields stay stable until completion.
- Completion: bus_ack_n sampled 0 in IBUS/DBUS.
  - bus_rdata is registered into i_rdata or d_rdata, passed raw with no extension or lane steering.
  - The matching ack pulses for one cycle.
  - bus_mreq drops and the state returns to IDLE.
- For stores, the returned rdata is don't-care and the register keeps its last value.
- i_rdata/d_rdata hold until the next completion for that requester.

## Timing
- All outputs are registered. Reset value of every output is 0. Reset also sets state to IDLE and starve_cnt/timeout counter to 0.
- Requester sampled at edge E0 → bus_mreq=1 after E0. Bus ack at edge E1 → ack=1 after E1. Best-case latency is 2 cycles request→ack, with back-to-back service every 3 cycles.
- bus_ack_n is ignored in IDLE.
- Reset asserted mid-transaction: bus_mreq drops asynchronously, no ack is issued, and the requester must re-request.
- Requests dropped before ack are illegal and are not checked.

## Configuration
- MEMARB_TIMEOUT_EN defined:
  - A counter runs in IBUS/DBUS.
  - If TIMEOUT cycles elapse without bus_ack_n=0, the transaction terminates: requester ack pulses with rdata=0, err pulses with it, bus_mreq drops, state goes to IDLE.
  - An ack arriving on the same edge as expiry wins, with normal completion and no err.
- MEMARB_TIMEOUT_EN undefined: the arbiter waits indefinitely, err is tied 0, and no counter is present.

## Structure
- Package mem_arb_pkg holds:
  - state enum (IDLE, IBUS, DBUS)
  - size constants SIZE_WORD=2'b00, SIZE_HALF=2'b01, SIZE_BYTE=2'b10
- One sub-module, mem_arb_prio: the IDLE-cycle priority decision plus starve_cnt register. It outputs grant_i/grant_d.

## Test plan
- Single fetch: i_addr=0x0000_0010, bus acks next cycle with bus_rdata=0x0000_0013 → bus_mreq for 1 cycle with bus_write=0, bus_size=00; i_ack with i_rdata=0x0000_0013 two cycles after request.
- Byte store: d_we=1, d_size=10, d_addr=0xF000_0000, d_wdata=0x41 → bus_write=1, bus_size=10, bus_addr=0xF000_0000, bus_wdata=0x41; d_ack follows bus ack.
- Contention: i_req and d_req held continuously, STARVE_MAX=4 → grant order D,D,D,D,I,D,D,D,D,I.
- Slow bus: bus_ack_n held high 5 cycles → bus fields stable throughout; single ack after bus_ack_n=0.
- Reset mid-DBUS: rst pulses while bus_mreq=1 → bus_mreq=0 immediately, no d_ack; fresh request after reset served normally.
- MEMARB_TIMEOUT_EN, TIMEOUT=16, bus never acks → d_ack and err pulse together on the 16th busy cycle, d_rdata=0; ack on cycle 16 → no err.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory bus arbiter:
// arbiter FSM states and the bus transfer-size encoding.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IBUS = 2'd1,
        DBUS = 2'd2
    } arb_state_e;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory-bus signal bundle for mem_bus_arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;

    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    logic              bus_mreq;
    logic              bus_write;
    logic [1:0]        bus_size;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack_n;

    logic              err;

    modport master (
        input  i_req, i_addr,
        output i_rdata, i_ack,
        input  d_req, d_we, d_size, d_addr, d_wdata,
        output d_rdata, d_ack,
        output bus_mreq, bus_write, bus_size, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack_n,
        output err
    );

    modport slave (
        output i_req, i_addr,
        input  i_rdata, i_ack,
        output d_req, d_we, d_size, d_addr, d_wdata,
        input  d_rdata, d_ack,
        input  bus_mreq, bus_write, bus_size, bus_addr, bus_wdata,
        output bus_rdata, bus_ack_n,
        input  err
    );

endinterface

// File: rtl/mem_arb_prio.sv
// IDLE-cycle priority decision between fetch and data, with the starvation
// counter that forces a fetch grant after STARVE_MAX data wins in contention.
module mem_arb_prio #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic idle_i,
    input  logic hold_i,
    input  logic ireq_i,
    input  logic dreq_i,
    output logic grant_i,
    output logic grant_d
);

    localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_q, starve_d;
    logic             fetch_due;

    // hold_i marks the turnaround cycle carrying an ack: no grant is made, so the
    // side whose request is masked by its own ack is not out-voted by the other.
    assign fetch_due = ireq_i && (starve_q == CNT_MAX);
    assign grant_d   = idle_i && !hold_i && dreq_i && !fetch_due;
    assign grant_i   = idle_i && !hold_i && ireq_i && (!dreq_i || fetch_due);

    always_comb begin
        starve_d = starve_q;
        if (idle_i) begin
            if (!ireq_i || grant_i) begin
                starve_d = '0;
            end else if (grant_d) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between instruction fetch and data access (data first,
// fetch protected by a starvation limit). Define MEMARB_TIMEOUT_EN for a bus timeout with err.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.master arb_if
);

    if (STARVE_MAX < 1 || TIMEOUT < 1) begin : g_param_check
        $error("mem_bus_arbiter: STARVE_MAX and TIMEOUT must be at least 1");
    end

    arb_state_e        state_q, state_d;
    logic              mreq_q, mreq_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] irdata_q, irdata_d;
    logic [DATA_W-1:0] drdata_q, drdata_d;
    logic              iack_q, iack_d;
    logic              dack_q, dack_d;

`ifdef MEMARB_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;
`endif

    logic ireq_eff, dreq_eff, grant_i, grant_d, in_idle, in_turnaround;

    // A requester is masked in the cycle its own ack is visible.
    assign ireq_eff      = arb_if.i_req && !iack_q;
    assign dreq_eff      = arb_if.d_req && !dack_q;
    assign in_idle       = (state_q == IDLE);
    assign in_turnaround = iack_q || dack_q;

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk     (clk),
        .rst     (rst),
        .idle_i  (in_idle),
        .hold_i  (in_turnaround),
        .ireq_i  (ireq_eff),
        .dreq_i  (dreq_eff),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    always_comb begin
        state_d  = state_q;
        mreq_d   = mreq_q;
        write_d  = write_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;
        iack_d   = 1'b0;
        dack_d   = 1'b0;
`ifdef MEMARB_TIMEOUT_EN
        err_d    = 1'b0;
        to_cnt_d = to_cnt_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef MEMARB_TIMEOUT_EN
                to_cnt_d = '0;
`endif
                if (grant_d) begin
                    state_d = DBUS;
                    mreq_d  = 1'b1;
                    write_d = arb_if.d_we;
                    size_d  = arb_if.d_size;
                    addr_d  = arb_if.d_addr;
                    wdata_d = arb_if.d_wdata;
                end else if (grant_i) begin
                    state_d = IBUS;
                    mreq_d  = 1'b1;
                    write_d = 1'b0;
                    size_d  = SIZE_WORD;
                    addr_d  = arb_if.i_addr;
                end
            end
            IBUS, DBUS: begin
                if (!arb_if.bus_ack_n) begin
                    state_d = IDLE;
                    mreq_d  = 1'b0;
                    if (state_q == IBUS) begin
                        iack_d   = 1'b1;
                        irdata_d = arb_if.bus_rdata;
                    end else begin
                        dack_d = 1'b1;
                        if (!write_q) begin
                            drdata_d = arb_if.bus_rdata;
                        end
                    end
                end
`ifdef MEMARB_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    state_d = IDLE;
                    mreq_d  = 1'b0;
                    err_d   = 1'b1;
                    if (state_q == IBUS) begin
                        iack_d   = 1'b1;
                        irdata_d = '0;
                    end else begin
                        dack_d   = 1'b1;
                        drdata_d = '0;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                mreq_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mreq_q   <= 1'b0;
            write_q  <= 1'b0;
            size_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
            iack_q   <= 1'b0;
            dack_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mreq_q   <= mreq_d;
            write_q  <= write_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
            iack_q   <= iack_d;
            dack_q   <= dack_d;
        end
    end

`ifdef MEMARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign arb_if.err = err_q;
`else
    assign arb_if.err = 1'b0;
`endif

    assign arb_if.bus_mreq  = mreq_q;
    assign arb_if.bus_write = write_q;
    assign arb_if.bus_size  = size_q;
    assign arb_if.bus_addr  = addr_q;
    assign arb_if.bus_wdata = wdata_q;
    assign arb_if.i_rdata   = irdata_q;
    assign arb_if.i_ack     = iack_q;
    assign arb_if.d_rdata   = drdata_q;
    assign arb_if.d_ack     = dack_q;

endmodule
